// File: rtl/regfile_store_array.sv
// Storage half of the 32x64 register file: one enabled DFF per stored bit, one-hot write
// decode, hardwired-zero register, and write acknowledge / written-map / zero-write flags.

module regfile_dff_en (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);
  logic q_d;
  logic q_q;

  // Next-state: load d when enabled, otherwise hold
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  // Storage flop with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

module regfile_store_array #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(NREGS)-1:0]     wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0][NREGS-1:0]  reg_bits,
  output logic                         wr_ack,
  output logic                         wr_zero_err,
  output logic [NREGS-1:0]             reg_written
);
  localparam int            AW        = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [NREGS-1:0] wr_sel_s;
  logic             commit_s;
  logic             zero_hit_s;
  logic [WIDTH-1:0] store_s [NREGS];

  logic             wr_ack_d,      wr_ack_q;
  logic             wr_zero_err_d, wr_zero_err_q;
  logic [NREGS-1:0] reg_written_d, reg_written_q;

  // Write decode; wr_en gates first so an unknown address with no strobe decodes to nothing
  always_comb begin
    wr_sel_s   = '0;
    commit_s   = 1'b0;
    zero_hit_s = 1'b0;
    if (wr_en) begin
      if (wr_addr == ZERO_ADDR) begin
        zero_hit_s = 1'b1;
      end else begin
        commit_s          = 1'b1;
        wr_sel_s[wr_addr] = 1'b1;
      end
    end else begin
      wr_sel_s = '0;
    end
  end

  genvar r, b;
  generate
    for (r = 0; r < NREGS; r++) begin : g_reg
      if (r == ZERO_REG) begin : g_zero
        assign store_s[r] = '0;
      end else begin : g_store
        for (b = 0; b < WIDTH; b++) begin : g_bit
          regfile_dff_en u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_sel_s[r]),
            .d     (wr_data[b]),
            .q     (store_s[r][b])
          );
        end
      end
    end
  endgenerate

  // Transpose register-major storage into bit-major rows for the read-mux bank
  always_comb begin
    reg_bits = '0;
    for (int bi = 0; bi < WIDTH; bi++) begin
      for (int ri = 0; ri < NREGS; ri++) begin
        reg_bits[bi][ri] = store_s[ri][bi];
      end
    end
  end

  // Status next-state: ack follows each committed write, error and written-map are sticky
  always_comb begin
    wr_ack_d      = commit_s;
    wr_zero_err_d = wr_zero_err_q | zero_hit_s;
    reg_written_d = reg_written_q | wr_sel_s;
  end

  // Status registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q      <= 1'b0;
      wr_zero_err_q <= 1'b0;
      reg_written_q <= '0;
    end else begin
      wr_ack_q      <= wr_ack_d;
      wr_zero_err_q <= wr_zero_err_d;
      reg_written_q <= reg_written_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign wr_zero_err = wr_zero_err_q;
  assign reg_written = reg_written_q;
endmodule
